// File: rtl/toggle_monitor.sv
// toggle_monitor: per-signal transition counter over a window of enabled
// cycles, with the finished window's counts streamed out one channel per beat.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   sig        monitored signals (synchronous to clk)
//   enable     counting enable; window progress and counting pause while low
//   out_valid  count beat presented
//   out_ready  downstream accepts the beat
//   out_idx    channel number of the current beat
//   out_count  toggle count of channel out_idx (saturating)
//   out_last   high on the beat for channel NUM_SIG-1
//   overflow   one-cycle pulse when a finished window is dropped (readout busy)

// One channel's saturating toggle counter. sum is the value the counter would
// take this edge, so the window-end snapshot includes the final cycle's toggle.
module toggle_monitor_lane #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tog,
  input  logic             clr,
  output logic [CNT_W-1:0] sum
);
  logic [CNT_W-1:0] cnt;

  assign sum = (tog && !(&cnt)) ? cnt + 1'b1 : cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     cnt <= '0;
    else if (clr) cnt <= '0;
    else          cnt <= sum;
  end
endmodule

module toggle_monitor #(
  parameter  int NUM_SIG = 4,
  parameter  int WINDOW  = 64,
  parameter  int CNT_W   = 8,
  localparam int IW      = (NUM_SIG > 1) ? $clog2(NUM_SIG) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SIG-1:0] sig,
  input  logic               enable,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IW-1:0]      out_idx,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_last,
  output logic               overflow
);
  localparam int            WW       = $clog2(WINDOW);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  logic [NUM_SIG-1:0]            sig_q;
  logic [NUM_SIG-1:0]            tog;
  logic                          primed;
  logic                          step;
  logic                          win_end;
  logic [WW-1:0]                 win;
  logic [NUM_SIG-1:0][CNT_W-1:0] cnt_sum;
  logic [NUM_SIG-1:0][CNT_W-1:0] snap;
  state_t                        state_q, state_d;
  logic                          load, adv;
  logic [IW-1:0]                 nxt_idx;

  // primed masks the first sample after reset, whose sig_q is the reset value
  // rather than a real previous sample.
  assign step    = primed & enable;
  assign tog     = step ? (sig ^ sig_q) : '0;
  assign win_end = step && (win == WIN_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_q  <= '0;
      primed <= 1'b0;
      win    <= '0;
    end else begin
      sig_q  <= sig;
      primed <= 1'b1;
      if (win_end)   win <= '0;
      else if (step) win <= win + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_SIG; g++) begin : g_lane
    toggle_monitor_lane #(.CNT_W(CNT_W)) u_lane (
      .clk (clk),
      .rst (rst),
      .tog (tog[g]),
      .clr (win_end),
      .sum (cnt_sum[g])
    );
  end

  // Readout FSM. A window ending while a stream is in flight (even on its
  // final handshake) is dropped; the stream in flight is never disturbed.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    adv     = 1'b0;
    case (state_q)
      IDLE: if (win_end) begin
        state_d = SEND;
        load    = 1'b1;
      end
      SEND: if (out_ready) begin
        if (out_last) state_d = IDLE;
        else          adv     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  assign out_valid = (state_q == SEND);
  assign nxt_idx   = out_idx + 1'b1;

  // Beat registers are loaded ahead of time so every output comes from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap      <= '0;
      out_idx   <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= win_end && (state_q == SEND);
      if (load) begin
        snap      <= cnt_sum;
        out_idx   <= '0;
        out_count <= cnt_sum[0];
        out_last  <= (NUM_SIG == 1);
      end else if (adv) begin
        out_idx   <= nxt_idx;
        out_count <= snap[nxt_idx];
        out_last  <= (nxt_idx == IW'(NUM_SIG - 1));
      end
    end
  end
endmodule

// File: doc/toggle_monitor.md
Name: toggle_monitor

Overview:
- Observes a bus of free-running digital signals, such as the pulse outputs of the clock-divider counter.
- Counts transitions per signal over a fixed window of enabled cycles and streams the per-signal toggle counts out one channel at a time over a valid/ready interface.
- Serves as the in-silicon consumer of the activity that traces capture, and provides a cross-check against switching counts extracted from dumps.

Parameters:
- NUM_SIG, 4, number of monitored signals (>=1).
- WINDOW, 64, enabled cycles per measurement window (>=2).
- CNT_W, 8, width of each toggle counter; counters saturate.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: asynchronous active-low reset.
- sig, input, NUM_SIG: monitored signals, synchronous to clk.
- enable, input, 1: counting enable; window progress and counting pause while low.
- out_valid, output, 1: a count beat is presented.
- out_ready, input, 1: downstream accepts the beat.
- out_idx, output, max(1,$clog2(NUM_SIG)): channel number of the current beat.
- out_count, output, CNT_W: toggle count for channel out_idx.
- out_last, output, 1: high on the beat for channel NUM_SIG-1.
- overflow, output, 1: one-cycle pulse when a finished window is dropped.

Behaviour:
- Reset (rst=0, asynchronous):
  - sig_q, toggle counters, window counter, primed and snapshot registers clear to 0.
  - FSM enters IDLE.
  - out_valid=0, out_idx=0, out_count=0, out_last=0, overflow=0.
- Sampling:
  - sig_q <= sig every cycle, regardless of enable.
  - primed <= 1 on the first clock after reset release.
  - A toggle on bit i is counted when primed && enable && (sig[i] != sig_q[i]).
  - The first sample after reset is therefore never counted.
- Counters:
  - Each per-channel counter increments by 1 per counted toggle.
  - Each counter saturates at 2^CNT_W-1 and never wraps.
- Window:
  - The window counter counts cycles with enable=1 && primed, from 0 to WINDOW-1.
  - On the cycle it equals WINDOW-1 with enable=1, the window ends:
    - The snapshot captures counter + toggle-this-cycle, with saturation.
    - All toggle counters and the window counter clear to 0 on the next edge.
  - enable low mid-window: window counter and toggle counters hold their values.
- Readout FSM, states IDLE and SEND:
  - IDLE -> SEND on window end. The snapshot loads and idx=0.
  - In SEND, out_valid=1, out_count=snapshot[idx], and out_last=(idx==NUM_SIG-1).
  - On out_valid&&out_ready with out_last=0, idx increments.
  - On out_valid&&out_ready with out_last=1, return to IDLE.
  - out_valid, out_idx and out_count hold stable while out_ready=0.
  - out_valid never drops without a handshake.
- Latency: the first beat is valid on the cycle after the window-end edge. The first beat is accepted at the earliest in that cycle.
- Busy collision:
  - If a window ends while in SEND, including on the final-handshake cycle, that window's snapshot is discarded and overflow pulses for 1 cycle.
  - Live counters still clear, and the current readout continues unchanged.
  - The FSM returns to IDLE after the final beat.
- Zero toggles: a window with no toggles still emits NUM_SIG beats with count 0.
- Reset mid-readout: out_valid drops immediately (asynchronous). The partial stream is abandoned.
- All outputs are registered.

Test Plan:
1. Toggle mix, out_ready=1:
   - Stimulus: drive sig from a free-running counter (sig[0] toggles every cycle, sig[1] every 2 cycles, sig[2] every 4, sig[3] every 8), with WINDOW=64 and enable=1.
   - Required: beats (idx,count) = (0,64),(1,32),(2,16),(3,8), out_last only on idx 3, repeating every 64 cycles with no overflow.
2. Backpressure:
   - Stimulus: same as scenario 1, with out_ready held low for 10 cycles after out_valid rises.
   - Required: beat 0 holds idx=0, count=64, stable for 10 cycles; the 4 beats then complete in order.
3. Saturation:
   - Stimulus: CNT_W=4, sig[0] toggling every cycle, WINDOW=64.
   - Required: channel 0 count=15; other channels unaffected.
4. Enable gating:
   - Stimulus: deassert enable for 20 cycles mid-window while sig[0] keeps toggling.
   - Required: the window ends 20 cycles later than in scenario 1, and the channel 0 count is still 64.
5. Overflow:
   - Stimulus: hold out_ready=0 across a second window end.
   - Required: overflow pulses exactly 1 cycle; the first window's beats are then delivered; the second window is never emitted.
6. Reset:
   - Stimulus: assert rst low during beat 2, then release with sig=4'b1111 static.
   - Required: out_valid=0 immediately, with no spurious toggles counted. After one window, all counts are 0.
